// File: rtl/gray_pkg.sv
// gray_pkg
//   Shared types and helpers for the pipelined Gray/binary converter.
//   - gray_mode_e : per-word conversion direction carried through the pipe
//   - chunk_size  : bits handled per stage, ceil(width / stages)
//   - chunk_lo    : LSB index of stage k's chunk (clamped at bit 0)
package gray_pkg;

    typedef enum logic {
        GRAY_DECODE = 1'b0,
        GRAY_ENCODE = 1'b1
    } gray_mode_e;

    function automatic int chunk_size(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    // With ceil-sized chunks the trailing stages can run past bit 0; they
    // then own an empty (or short) chunk and simply forward the carry.
    function automatic int chunk_lo(input int width, input int ch, input int k);
        int lo;
        lo = width - (k + 1) * ch;
        return (lo < 0) ? 0 : lo;
    endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// gray_pipe_stage
//   Combinational conversion of one chunk [HI:LO] of a word in flight.
//   Parameters : WIDTH word width, HI/LO chunk bounds (HI < LO = empty chunk),
//                FIRST nonzero for the stage that performs the full encode.
//   Ports      : word_i/mode_i/carry_i  word, direction, binary bit above chunk
//                word_o/carry_o         updated word, binary value of chunk LSB
module gray_pipe_stage
    import gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HI    = 7,
    parameter int LO    = 0,
    parameter int FIRST = 1
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic             mode_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] word_o,
    output logic             carry_o
);

    logic run;

    always_comb begin
        word_o  = word_i;
        carry_o = carry_i;
        run     = carry_i;
        if (mode_i == GRAY_ENCODE) begin
            // Encode is a single XOR layer, done whole in the first stage;
            // later stages just carry the finished word along.
            if (FIRST != 0) word_o = word_i ^ (word_i >> 1);
            carry_o = 1'b0;
        end else begin
            // Ripple from chunk MSB down; bits outside the chunk untouched.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (i <= HI && i >= LO) begin
                    run       = run ^ word_i[i];
                    word_o[i] = run;
                end
            end
            carry_o = run;
        end
    end

endmodule

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe
//   Pipelined Gray<->binary converter with valid/ready on both sides and a
//   per-word direction bit. The decode ripple is split into STAGES registered
//   chunks; encode finishes in stage 0 and rides along.
//   Parameters : WIDTH (>=2), STAGES (1..WIDTH)
//   Ports      : clk, rst_n (async, active low)
//                in_valid/in_ready/in_data/in_mode   upstream handshake + word
//                out_valid/out_ready/out_data/out_mode downstream handshake
module gray_codec_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode
);

    localparam int CH = chunk_size(WIDTH, STAGES);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
        gray_mode_e       mode;
        logic             carry;
    } slot_t;

    slot_t slot_q [STAGES];

    // Per-stage combinational results feeding slot k.
    logic [STAGES-1:0][WIDTH-1:0] nxt_data_d;
    logic [STAGES-1:0]            nxt_carry_d;
    logic [STAGES-1:0]            up_vld;
    logic [STAGES-1:0]            up_mode;
    logic [STAGES-1:0]            adv;
    logic                         hold;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_vld[k]  = in_valid;
            assign up_mode[k] = in_mode;
            gray_pipe_stage #(
                .WIDTH (WIDTH),
                .HI    (WIDTH - 1),
                .LO    (chunk_lo(WIDTH, CH, 0)),
                .FIRST (1)
            ) u_stage (
                .word_i  (in_data),
                .mode_i  (in_mode),
                .carry_i (1'b0),
                .word_o  (nxt_data_d[k]),
                .carry_o (nxt_carry_d[k])
            );
        end else begin : g_body
            assign up_vld[k]  = slot_q[k-1].vld;
            assign up_mode[k] = slot_q[k-1].mode;
            gray_pipe_stage #(
                .WIDTH (WIDTH),
                .HI    (WIDTH - 1 - k * CH),
                .LO    (chunk_lo(WIDTH, CH, k)),
                .FIRST (0)
            ) u_stage (
                .word_i  (slot_q[k-1].data),
                .mode_i  (slot_q[k-1].mode),
                .carry_i (slot_q[k-1].carry),
                .word_o  (nxt_data_d[k]),
                .carry_o (nxt_carry_d[k])
            );
        end
    end

    // A slot is stuck only if it is full and everything below it is stuck;
    // walking from the output end keeps this a plain AND chain.
    always_comb begin
        adv  = '0;
        hold = !out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hold   = hold && slot_q[k].vld;
            adv[k] = !hold;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = slot_q[STAGES-1].vld;
    assign out_data  = slot_q[STAGES-1].data;
    assign out_mode  = slot_q[STAGES-1].mode;

    // Payload only reloads when a real word arrives, so an emptied slot
    // keeps its last contents instead of toggling on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) slot_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    slot_q[k].vld <= up_vld[k];
                    if (up_vld[k]) begin
                        slot_q[k].data  <= nxt_data_d[k];
                        slot_q[k].mode  <= gray_mode_e'(up_mode[k]);
                        slot_q[k].carry <= nxt_carry_d[k];
                    end
                end
            end
        end
    end

endmodule
